// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: retires up to two bits of shift amount per
// cycle through fixed shift-by-2 / shift-by-1 steps instead of a barrel shifter.
//
// state   | meaning
// IDLE    | waiting for a request, ready=1
// SHIFT   | applying 2-bit / 1-bit steps, busy=1
// DONE    | result valid for one cycle, done=1, ready=1
module shift_sequencer #(
  parameter  int WIDTH   = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   operand,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               flush,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [1:0]         op_q, op_d;

  logic               accept;
  logic               step2;
  logic [WIDTH-1:0]   acc_sh1, acc_sh2, acc_step;
  logic [SHAMT_W-1:0] rem_step;

  assign accept = start && !flush && (state_q == S_IDLE || state_q == S_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) state_d = (shamt != '0) ? S_SHIFT : S_DONE;
          else        state_d = S_IDLE;
        end
        S_SHIFT: state_d = (rem_step == '0) ? S_DONE : S_SHIFT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      S_IDLE:  ready = 1'b1;
      S_SHIFT: busy  = 1'b1;
      S_DONE: begin
        done  = 1'b1;
        ready = 1'b1;
      end
      default: ready = 1'b0;
    endcase
  end

  // Both step widths are built every cycle; remaining picks which one retires.
  always_comb begin
    acc_sh1 = acc_q;
    acc_sh2 = acc_q;
    case (op_q)
      OP_SLL: begin
        acc_sh1 = {acc_q[WIDTH-2:0], 1'b0};
        acc_sh2 = {acc_q[WIDTH-3:0], 2'b00};
      end
      OP_SRL: begin
        acc_sh1 = {1'b0, acc_q[WIDTH-1:1]};
        acc_sh2 = {2'b00, acc_q[WIDTH-1:2]};
      end
      OP_SRA: begin
        acc_sh1 = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
        acc_sh2 = {{2{acc_q[WIDTH-1]}}, acc_q[WIDTH-1:2]};
      end
      OP_ROR: begin
        acc_sh1 = {acc_q[0], acc_q[WIDTH-1:1]};
        acc_sh2 = {acc_q[1:0], acc_q[WIDTH-1:2]};
      end
      default: begin
        acc_sh1 = acc_q;
        acc_sh2 = acc_q;
      end
    endcase
  end

  assign step2    = (rem_q >= SHAMT_W'(2));
  assign acc_step = step2 ? acc_sh2 : acc_sh1;
  assign rem_step = step2 ? (rem_q - SHAMT_W'(2)) : '0;

  always_comb begin
    acc_d = acc_q;
    rem_d = rem_q;
    op_d  = op_q;
    if (!flush) begin
      if (accept) begin
        acc_d = operand;
        rem_d = shamt;
        op_d  = op;
      end else if (state_q == S_SHIFT) begin
        acc_d = acc_step;
        rem_d = rem_step;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      rem_q <= '0;
      op_q  <= OP_SLL;
    end else begin
      acc_q <= acc_d;
      rem_q <= rem_d;
      op_q  <= op_d;
    end
  end

  assign result = acc_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed plan cases plus random
// requests checked against a whole-shift arithmetic reference.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand;
  logic [4:0]  shamt;
  logic        flush;
  logic        ready, busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  shift_sequencer #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .operand (operand),
    .shamt   (shamt),
    .flush   (flush),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  // Whole shift in one go; the DUT's stepping must land on the same value.
  function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] v,
                                             input logic [4:0] s);
    logic [63:0] dbl;
    case (o)
      2'b00:   return v << s;
      2'b01:   return v >> s;
      2'b10:   return 32'($signed(v) >>> s);
      default: begin
        dbl = {v, v} >> s;
        return dbl[31:0];
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request in the current cycle (cycle 0) and follows it to DONE.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] v,
                        input logic [4:0] s, input logic [31:0] exp);
    int n;
    n       = (int'(s) + 1) / 2;
    op      = o;
    operand = v;
    shamt   = s;
    start   = 1'b1;
    step();
    start   = 1'b0;
    operand = $urandom;
    shamt   = 5'($urandom);
    op      = 2'($urandom);
    for (int i = 1; i <= n; i++) begin
      chk({tag, " busy"}, 32'(busy), 32'd1);
      chk({tag, " done_early"}, 32'(done), 32'd0);
      step();
    end
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " ready_in_done"}, 32'(ready), 32'd1);
    chk({tag, " result"}, result, exp);
    step();
    chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
    chk({tag, " result_hold"}, result, exp);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] rv;
    logic [4:0]  rs;

    reset = 1'b1; start = 1'b0; flush = 1'b0;
    op = 2'b00; operand = '0; shamt = '0;
    #1;
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", result, 32'd0);
    step(); step();
    reset = 1'b0;
    step();

    run_op("sll_2",   2'b00, 32'h0000_0002, 5'd2,  32'h0000_0008);
    run_op("sra_31",  2'b10, 32'hFFFF_FFFC, 5'd31, 32'hFFFF_FFFF);
    run_op("srl_31",  2'b01, 32'hFFFF_FFFC, 5'd31, 32'h0000_0001);
    run_op("ror_1",   2'b11, 32'h8000_0001, 5'd1,  32'hC000_0000);
    run_op("srl_5",   2'b01, 32'hFFFF_FFFC, 5'd5,  32'h07FF_FFFF);
    run_op("srl_0",   2'b01, 32'h1234_5678, 5'd0,  32'h1234_5678);

    // Back-to-back: second request accepted in the first request's DONE cycle.
    op = 2'b00; operand = 32'h1; shamt = 5'd3; start = 1'b1;
    step();
    operand = 32'hFFFF_FFFF; shamt = 5'd31; op = 2'b11;
    chk("b2b_busy1", 32'(busy), 32'd1);
    step();
    chk("b2b_busy2", 32'(busy), 32'd1);
    step();
    chk("b2b_done1", 32'(done), 32'd1);
    chk("b2b_result1", result, 32'h0000_0008);
    op = 2'b00; operand = 32'h3; shamt = 5'd4;
    step();
    start = 1'b0; operand = 32'hFFFF_FFFF;
    chk("b2b_no_bubble", 32'(busy), 32'd1);
    step();
    chk("b2b_busy4", 32'(busy), 32'd1);
    step();
    chk("b2b_done2", 32'(done), 32'd1);
    chk("b2b_result2", result, 32'h0000_0030);
    step();
    chk("b2b_idle", 32'(done), 32'd0);

    // Flush in cycle 4 with a competing start.
    op = 2'b10; operand = 32'h8000_0000; shamt = 5'd20; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("flush_busy_c4", 32'(busy), 32'd1);
    flush = 1'b1; start = 1'b1; shamt = 5'd0;
    step();
    flush = 1'b0; start = 1'b0;
    chk("flush_ready", 32'(ready), 32'd1);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_done", 32'(done), 32'd0);
    for (int i = 0; i < 12; i++) begin
      chk("flush_no_done", 32'(done), 32'd0);
      step();
    end

    // Async reset in cycle 3, no clock edge needed.
    op = 2'b10; operand = 32'h8000_0000; shamt = 5'd20; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    chk("rst_busy_c3", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_result", result, 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd0);
    chk("rst_async_done", 32'(done), 32'd0);
    chk("rst_async_ready", 32'(ready), 32'd1);
    step();
    reset = 1'b0;
    step();
    run_op("after_reset", 2'b10, 32'hF000_1234, 5'd7, ref_shift(2'b10, 32'hF000_1234, 5'd7));

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      rv = $urandom;
      rs = 5'($urandom);
      run_op($sformatf("rand%0d", i), ro, rv, rs, ref_shift(ro, rv, rs));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

- Multi-cycle shift controller for the non-pipelined processor's ALU.
- Accepts a shift request (operation, operand, amount) through a start/ready handshake.
- Sequences the shift through a fixed shift-by-2 / shift-by-1 step datapath, retiring up to 2 bits of shift amount per cycle, then reports the result with a one-cycle done pulse.
- Sits between the main control unit and the ALU result mux; replaces a full barrel shifter to save area.

## Interface
- WIDTH, 32, data width; power of two, >= 4. SHAMT_W = log2(WIDTH) (5 at default).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted on a rising edge when ready=1.
- op  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- operand  in  WIDTH  value to shift; sampled only on accept.
- shamt  in  SHAMT_W  shift amount, 0..WIDTH-1; sampled only on accept.
- flush  in  1  synchronous abort of the current operation.
- ready  out  1  high in IDLE and DONE.
- busy  out  1  high in SHIFT.
- done  out  1  one-cycle pulse; result is valid while done=1.
- result  out  WIDTH  accumulator value.

## Operation
- States and their outputs:
  - IDLE: ready=1.
  - SHIFT: busy=1.
  - DONE: done=1, ready=1.
- Reset (async, any state): state=IDLE, accumulator/result=0, remaining=0, latched op=00, done=0, busy=0, ready=1.
- Accept (start=1 and ready=1 at an edge, flush=0):
  - Latches op, loads accumulator=operand and remaining=shamt.
  - Next state is SHIFT if shamt!=0, otherwise DONE.
  - start while busy is ignored and not queued.
- SHIFT, each edge:
  - remaining>=2: apply a 2-bit step, remaining -= 2.
  - remaining==1: apply a 1-bit step, remaining=0.
  - Next state is DONE when the updated remaining is 0.
- Step semantics (k = 1 or 2):
  - SLL: zero-fill from the LSB.
  - SRL: zero-fill from the MSB.
  - SRA: fill with the accumulator MSB.
  - ROR: bits leaving the LSB re-enter at the MSB.
- DONE lasts one cycle. Next state is SHIFT/DONE if a new start is accepted that edge, otherwise IDLE.
- result equals the accumulator:
  - Changes during SHIFT and is not meaningful there.
  - Holds its final value from DONE until the next accept.
- flush=1 at an edge (reset not asserted):
  - Next state is IDLE; start that edge is ignored; done is not asserted for the aborted operation.
  - Accumulator holds its partial value, which has no meaning.
- Priority: reset > flush > accept.
- Input changes to operand, shamt or op after accept have no effect on the operation in flight.
- remaining is SHAMT_W bits wide; no arithmetic wraps, since the decrement never goes below 0.

## Timing
- Cycle 0 is the cycle in which start is accepted.
- N = ceil(shamt/2) SHIFT cycles: cycles 1..N. done=1 in cycle N+1.
  - shamt=0: done in cycle 1.
  - shamt=31: done in cycle 17.
- Back-to-back: start held high in the DONE cycle is accepted. No idle bubble; the next request's cycle 0 is the DONE cycle.
- Throughput: one result per N+1 cycles.
- All outputs are registered or decoded from the state register only; there is no combinational path from input to output.
- Reset mid-operation: outputs take their reset values immediately (asynchronous); the operation is lost.

## Test plan
- SLL, operand=0x00000002, shamt=2 -> busy in cycle 1; done=1 in cycle 2, result=0x00000008.
- SRA, operand=0xFFFFFFFC, shamt=31 -> busy for cycles 1..16; done in cycle 17, result=0xFFFFFFFF. SRL with the same inputs -> result=0x00000001.
- ROR, operand=0x80000001, shamt=1 -> done in cycle 2, result=0xC0000000. SRL, operand=0xFFFFFFFC, shamt=5 -> done in cycle 4, result=0x07FFFFFF.
- SRL, operand=0x12345678, shamt=0 -> no busy cycle; done in cycle 1, result=0x12345678.
- SLL, operand=0x1, shamt=3 with start held high through DONE, then a second request SLL, operand=0x3, shamt=4 accepted in that DONE cycle:
  - first done shows result=0x00000008;
  - second done follows 3 cycles later with result=0x00000030;
  - operand changed to 0xFFFFFFFF mid-operation has no effect.
- Flush and reset mid-operation, SRA, shamt=20:
  - flush in cycle 4 -> IDLE in cycle 5, ready=1, done never pulses; a start issued alongside the flush is ignored.
  - reset asserted in cycle 3 -> result=0, busy=0, done=0 with no clock edge needed; a fresh request after deassert completes normally.
